// File: rtl/fabric32_pkg.sv
// Shared definitions for the 32x32 shortest-path fabric and its writeback stage:
// region addresses, grid and field widths, writeback state encoding and an
// address helper.
package fabric32_pkg;

  // Memory map of the txn memory regions (byte addresses)
  localparam logic [31:0] ADDR_MAP  = 32'h4000_1000;  // weight map
  localparam logic [31:0] ADDR_DIR  = 32'h4000_2000;  // direction region
  localparam logic [31:0] ADDR_COST = 32'h4000_3000;  // cost region

  localparam int unsigned GRID_DIM = 32;
  localparam int unsigned NODES    = GRID_DIM * GRID_DIM;

  localparam int unsigned DIR_W    = 3;
  localparam int unsigned COST_W   = 12;
  localparam int unsigned WEIGHT_W = 4;

  // Direction words use the weight-map packing: 8 nibbles per 32-bit word
  localparam int unsigned NIBBLES_PER_WORD = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GATHER = 3'd1,
    ST_REQ    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } wb_state_e;

  // Byte address of 32-bit word idx within a region starting at base
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [8:0] idx);
    return base + {21'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/fabric32_nibble_pack.sv
// Indexed capture register: SLOTS slots of SLOT_W bits each, one slot written
// per capture, with synchronous clear. word_next is the register value with the
// current capture already merged, so the caller can use a word in the same
// cycle its last slot is captured.
module fabric32_nibble_pack #(
  parameter int unsigned SLOT_W = 4,
  parameter int unsigned SLOTS  = 8,
  localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      clr,
  input  logic                      cap,
  input  logic [IDX_W-1:0]          idx,
  input  logic [SLOT_W-1:0]         din,
  output logic [SLOT_W*SLOTS-1:0]   word_next
);

  logic [SLOT_W*SLOTS-1:0] word_q;
  logic [SLOT_W*SLOTS-1:0] word_d;

  // Next pack value: clear, or overwrite the addressed slot
  always_comb begin
    word_d = word_q;
    if (clr) begin
      word_d = '0;
    end else if (cap) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        if (idx == IDX_W'(i)) begin
          word_d[i*SLOT_W +: SLOT_W] = din;
        end else begin
          word_d[i*SLOT_W +: SLOT_W] = word_q[i*SLOT_W +: SLOT_W];
        end
      end
    end else begin
      word_d = word_q;
    end
  end

  // Pack register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_next = word_d;

endmodule

// File: rtl/fabric32_dir_wb.sv
// Direction writeback for the 32x32 shortest-path fabric. On start it walks all
// nodes, packs 8 three-bit directions per word and writes the words to the
// direction region over the txn memory port, then pulses done.
// Optional build macro DIR_WB_COST_EN: after the direction words, also writes
// the 12-bit node costs (two per word) to the cost region before done.
module fabric32_dir_wb #(
  parameter logic [31:0] DIR_BASE  = fabric32_pkg::ADDR_DIR,
  parameter logic [31:0] COST_BASE = fabric32_pkg::ADDR_COST,
  parameter int unsigned NODES     = fabric32_pkg::NODES
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [9:0]                       node_sel,
  input  logic [fabric32_pkg::DIR_W-1:0]   node_dir,
  input  logic [fabric32_pkg::COST_W-1:0]  node_cost,
  output logic                             txn_req,
  output logic                             txn_wr,
  output logic [31:0]                      txn_addr,
  output logic [31:0]                      txn_wdata,
  input  logic                             txn_rdy
);

  import fabric32_pkg::*;

  localparam int unsigned DIR_WORDS     = NODES / NIBBLES_PER_WORD;
  localparam logic [6:0]  LAST_DIR_WORD = 7'(DIR_WORDS - 1);

  wb_state_e   state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        txn_req_q, txn_req_d;
  logic        txn_wr_q, txn_wr_d;
  logic [31:0] txn_addr_q, txn_addr_d;
  logic [31:0] txn_wdata_q, txn_wdata_d;
  logic [9:0]  node_sel_q, node_sel_d;
  logic [6:0]  word_idx_q, word_idx_d;

  logic        pack_clr;
  logic        dpk_cap;
  logic [31:0] dpk_word;
  logic        last_slot;
  logic [31:0] gather_word;
  logic [31:0] gather_addr;

  fabric32_nibble_pack #(
    .SLOT_W (WEIGHT_W),
    .SLOTS  (NIBBLES_PER_WORD)
  ) u_dir_pack (
    .clk       (clk),
    .arst_n    (arst_n),
    .clr       (pack_clr),
    .cap       (dpk_cap),
    .idx       (node_sel_q[2:0]),
    .din       ({1'b0, node_dir}),
    .word_next (dpk_word)
  );

`ifdef DIR_WB_COST_EN
  localparam logic [8:0] LAST_COST_WORD = 9'(NODES / 2 - 1);

  logic        cost_ph_q, cost_ph_d;
  logic [8:0]  cost_idx_q, cost_idx_d;
  logic        cpk_cap;
  logic [31:0] cpk_word;

  fabric32_nibble_pack #(
    .SLOT_W (16),
    .SLOTS  (2)
  ) u_cost_pack (
    .clk       (clk),
    .arst_n    (arst_n),
    .clr       (pack_clr),
    .cap       (cpk_cap),
    .idx       (node_sel_q[0]),
    .din       ({4'b0000, node_cost}),
    .word_next (cpk_word)
  );

  assign dpk_cap     = (state_q == ST_GATHER) && !cost_ph_q;
  assign cpk_cap     = (state_q == ST_GATHER) && cost_ph_q;
  assign last_slot   = cost_ph_q ? node_sel_q[0] : (node_sel_q[2:0] == 3'd7);
  assign gather_word = cost_ph_q ? cpk_word : dpk_word;
  assign gather_addr = cost_ph_q ? word_addr(COST_BASE, cost_idx_q)
                                 : word_addr(DIR_BASE, {2'b00, word_idx_q});
`else
  // Cost inputs and region have no consumer in this build
  localparam logic [31:0] cost_base_unused = COST_BASE;
  logic [COST_W-1:0] node_cost_unused;
  assign node_cost_unused = node_cost;

  assign dpk_cap     = (state_q == ST_GATHER);
  assign last_slot   = (node_sel_q[2:0] == 3'd7);
  assign gather_word = dpk_word;
  assign gather_addr = word_addr(DIR_BASE, {2'b00, word_idx_q});
`endif

  // Next-state and next-output logic of the writeback sequencer
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    txn_req_d   = 1'b0;
    txn_wr_d    = txn_wr_q;
    txn_addr_d  = txn_addr_q;
    txn_wdata_d = txn_wdata_q;
    node_sel_d  = node_sel_q;
    word_idx_d  = word_idx_q;
    pack_clr    = 1'b0;
`ifdef DIR_WB_COST_EN
    cost_ph_d   = cost_ph_q;
    cost_idx_d  = cost_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_GATHER;
          busy_d     = 1'b1;
          node_sel_d = 10'd0;
          word_idx_d = 7'd0;
          pack_clr   = 1'b1;
`ifdef DIR_WB_COST_EN
          cost_ph_d  = 1'b0;
          cost_idx_d = 9'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GATHER: begin
        // node_sel wraps 1023 -> 0 after the last node
        node_sel_d = node_sel_q + 10'd1;
        if (last_slot) begin
          // Word is complete including this cycle's capture: issue it
          state_d     = ST_REQ;
          txn_req_d   = 1'b1;
          txn_wr_d    = 1'b1;
          txn_addr_d  = gather_addr;
          txn_wdata_d = gather_word;
        end else begin
          state_d = ST_GATHER;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (txn_rdy) begin
          txn_wr_d = 1'b0;
`ifdef DIR_WB_COST_EN
          if (cost_ph_q) begin
            cost_idx_d = cost_idx_q + 9'd1;
            if (cost_idx_q == LAST_COST_WORD) begin
              state_d   = ST_DONE;
              done_d    = 1'b1;
              busy_d    = 1'b0;
              cost_ph_d = 1'b0;
            end else begin
              state_d = ST_GATHER;
            end
          end else begin
            word_idx_d = word_idx_q + 7'd1;
            if (word_idx_q == LAST_DIR_WORD) begin
              state_d    = ST_GATHER;
              cost_ph_d  = 1'b1;
              cost_idx_d = 9'd0;
              node_sel_d = 10'd0;
            end else begin
              state_d = ST_GATHER;
            end
          end
`else
          word_idx_d = word_idx_q + 7'd1;
          if (word_idx_q == LAST_DIR_WORD) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_GATHER;
          end
`endif
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        // start seen in this cycle is deliberately not examined
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      txn_req_q   <= 1'b0;
      txn_wr_q    <= 1'b0;
      txn_addr_q  <= DIR_BASE;
      txn_wdata_q <= 32'd0;
      node_sel_q  <= 10'd0;
      word_idx_q  <= 7'd0;
`ifdef DIR_WB_COST_EN
      cost_ph_q   <= 1'b0;
      cost_idx_q  <= 9'd0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      txn_req_q   <= txn_req_d;
      txn_wr_q    <= txn_wr_d;
      txn_addr_q  <= txn_addr_d;
      txn_wdata_q <= txn_wdata_d;
      node_sel_q  <= node_sel_d;
      word_idx_q  <= word_idx_d;
`ifdef DIR_WB_COST_EN
      cost_ph_q   <= cost_ph_d;
      cost_idx_q  <= cost_idx_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign txn_req   = txn_req_q;
  assign txn_wr    = txn_wr_q;
  assign txn_addr  = txn_addr_q;
  assign txn_wdata = txn_wdata_q;
  assign node_sel  = node_sel_q;

endmodule

// File: doc/fabric32_dir_wb.md
Name: fabric32_dir_wb

Overview:
- Downstream stage of the 32x32 shortest-path fabric.
- After a run converges, walks all 1024 nodes, reads each node's 3-bit direction and packs 8 nodes per 32-bit word (4-bit nibbles, same packing as the weight map).
- Writes 128 words to the direction region over the shared txn memory interface, then raises a done pulse.
- Owns the memory port only while busy; the fabric's loader owns it otherwise.

Parameters:
- DIR_BASE, 32'h40002000, byte address of the direction region.
- COST_BASE, 32'h40003000, byte address of the cost region (used only with DIR_WB_COST_EN).
- NODES, 1024, node count; must be a multiple of 8.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset: asynchronous, active-low
- start  in  1  one-cycle pulse that begins a writeback; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse on completion (interrupt source)
- node_sel  out  10  node index presented to the fabric; node = y*32+x
- node_dir  in  3  direction of node_sel, combinational from the fabric, valid the same cycle
- node_cost  in  12  cost of node_sel, same timing; ignored without DIR_WB_COST_EN
- txn_req  out  1  one-cycle request pulse
- txn_wr  out  1  1 = write; always 1 when txn_req is high
- txn_addr  out  32  byte address, held from req until rdy
- txn_wdata  out  32  write data, held from req until rdy
- txn_rdy  in  1  transaction complete; sampled only in ST_WAIT

Behaviour:
- Reset values: busy=0, done=0, txn_req=0, txn_wr=0, txn_addr=DIR_BASE, txn_wdata=0, node_sel=0; state ST_IDLE; word_idx=0.
- ST_IDLE:
  - start=1 -> node_sel=0, word_idx=0, go to ST_GATHER.
  - Otherwise stay.
- ST_GATHER (8 cycles):
  - Each cycle, capture {1'b0,node_dir} into nibble node_sel[2:0] of the pack register (bits 4i+3:4i), then increment node_sel.
  - When the nibble-7 capture completes -> ST_REQ.
- ST_REQ (1 cycle):
  - txn_req=1, txn_wr=1.
  - txn_addr = DIR_BASE + (word_idx<<2); txn_wdata = pack register.
  - -> ST_WAIT.
- ST_WAIT:
  - Address and data held stable.
  - txn_rdy=1 -> increment word_idx. If word_idx was 127 -> ST_DONE, else -> ST_GATHER.
  - txn_rdy may arrive no earlier than the cycle after req; unbounded wait allowed, no timeout.
- ST_DONE (1 cycle): done=1, busy=0 -> ST_IDLE.
- Latency: minimum 8+1+1 = 10 cycles per word; 1280 cycles + 1 done cycle total with a single-cycle-rdy memory.
- Widths: node_sel wraps 1023->0 after the last gather; word_idx is 7 bits; address arithmetic is 32-bit, no overflow possible.
- Boundary cases:
  - start while busy: ignored, no restart.
  - txn_rdy outside ST_WAIT: ignored.
  - start in the same cycle as done: ignored. A new start is accepted from the following cycle.
  - Reset mid-operation: immediate return to reset values. A partial region may remain in memory; software must re-issue start.
- The fabric must be frozen (no run) while busy; this block does not check that.

Optional Feature:
- DIR_WB_COST_EN defined:
  - After the 128th direction word completes, a cost phase runs instead of ST_DONE.
  - node_sel restarts at 0. Two nodes are gathered per word: txn_wdata = {4'b0,cost[n+1],4'b0,cost[n]}.
  - 512 words are written to COST_BASE + (k<<2) using the same REQ/WAIT handshake; then ST_DONE.
- Not defined: the cost phase is absent, node_cost is unused, and done follows the 128th direction word.

Decomposition:
- Shared package fabric32_pkg:
  - ADDR_MAP, ADDR_DIR, ADDR_COST, GRID_DIM=32, NODES=1024.
  - DIR_W=3, COST_W=12, WEIGHT_W=4.
  - Writeback state encoding constants; nibble-packing helper constant NIBBLES_PER_WORD=8.
- One natural sub-module, fabric32_nibble_pack: an 8x4-bit indexed capture register with clear. It is reused for 2x16-bit cost packing via a width parameter.

Test Plan:
- Dirs all 3'd5, start pulse, 1-cycle rdy memory -> 128 writes of 32'h55555555 to 0x40002000..0x400021FC; done at cycle 1281 after start; busy low afterward.
- dir = node_sel[2:0] -> every word 32'h76543210; node 1023 lands in word 127 bits [31:28].
- rdy delayed 20 cycles on word 3 -> addr 0x4000200C and wdata held stable for all 20 cycles; no extra txn_req pulse; node_sel does not advance.
- Second start at cycle 500 while busy -> ignored; exactly 128 writes; one done pulse.
- arst_n low during word 60 wait -> txn_req=0, busy=0 next edge; a fresh start writes from word 0 correctly.
- DIR_WB_COST_EN, cost = node index -> 512 extra writes; word 0 = 32'h00010000; last at 0x400037FC = 32'h03FF03FE; done after the cost phase.
